pwm_capture: RTL

Measures an incoming PWM waveform and reports its high time and period in clock cycles, once per period. It is the receive-side counterpart of the LED PWM generator: it can loop back a generated channel or read an external dimmer/PWM source, and it feeds duty readback into the mood-lighting control logic. A constant input level produces no edges, so the block reports it as a stuck 0 % or 100 % condition after a timeout.

---
 rtl/pwm_capture.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM capture: reports high time and period of pwm_in in clk cycles once per period,
// with stuck-0/1 detection on timeout. Define PWM_CAP_FILTER_EN to add a glitch filter.
module pwm_capture #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TIMEOUT  = 16'd60000,
  parameter int               FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_cnt,
  output logic [WIDTH-1:0] period_cnt,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic             s0;
  logic             s1;
  logic             lvl;
  logic             lvl_d;
  logic             rise;
  logic             publish;
  logic             timeout_fire;
  logic [WIDTH-1:0] tot;
  logic [WIDTH-1:0] hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      s0    <= pwm_in;
      s1    <= s0;
      lvl_d <= lvl;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic          filt;
  logic [FW-1:0] filt_cnt;

  // The filtered level follows s1 only after FILT_LEN consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt     <= 1'b0;
      filt_cnt <= '0;
    end else if (s1 != filt) begin
      if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt     <= s1;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign lvl = filt;
`else
  // FILT_LEN only matters when the filter is built in
  logic unused_filt_len;
  assign unused_filt_len = (FILT_LEN > 0);
  assign lvl = s1;
`endif

  assign rise = lvl & ~lvl_d;

  // The rise cycle is the first high cycle of the new period, hence the load of 1
  always_ff @(posedge clk) begin
    if (rst) begin
      tot <= '0;
      hi  <= '0;
    end else if (rise) begin
      tot <= ONE;
      hi  <= ONE;
    end else begin
      if (tot != MAXV) tot <= tot + ONE;
      if (lvl && (hi != MAXV)) hi <= hi + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    publish      = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = MEAS;
        end else if ((tot == TIMEOUT) && !stuck) begin
          timeout_fire = 1'b1;
        end
      end
      MEAS: begin
        if (rise) begin
          publish = 1'b1;
        end else if (tot == TIMEOUT) begin
          state_next   = IDLE;
          timeout_fire = !stuck;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reported values only move on the cycle valid is high
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_cnt    <= '0;
      period_cnt  <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      valid <= publish | timeout_fire;
      if (publish) begin
        duty_cnt   <= hi;
        period_cnt <= tot;
        stuck      <= 1'b0;
      end else if (timeout_fire) begin
        duty_cnt    <= lvl ? TIMEOUT : '0;
        period_cnt  <= TIMEOUT;
        stuck       <= 1'b1;
        stuck_level <= lvl;
      end
    end
  end

endmodule
